// File: rtl/prefix_tree_subtractor_if.sv
// Operand/result handshake bundle for the pipelined prefix-tree subtractor.
interface prefix_tree_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero
  );
endinterface

// File: rtl/prefix_tree_subtractor.sv
// Pipelined a - b - bin computed as a + ~b + ~bin through a generate/propagate
// prefix tree, one register stage per prefix level, global-stall flow control.

module prefix_tree_subtractor_cell (
  input  logic i_g,
  input  logic i_p,
  input  logic i_gs,
  input  logic i_ps,
  output logic o_g,
  output logic o_p
);
  assign o_g = i_g | (i_gs & i_p);
  assign o_p = i_p & i_ps;
endmodule

module prefix_tree_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  prefix_tree_subtractor_if.slave  bus
);

  function automatic int clogb2(input int x);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      if ((x >> i) != 0) n = i + 1;
    return n;
  endfunction

  // WIDTH >= 1 guarantees at least two levels, so stages 1..DEPTH-1 always exist.
  localparam int DEPTH = clogb2(WIDTH + 1);

  logic [WIDTH:0]   w_g0, w_p0;
  logic [WIDTH:0]   w_gi [1:DEPTH];
  logic [WIDTH:0]   w_pi [1:DEPTH];
  logic [WIDTH:0]   w_go [1:DEPTH];
  logic [WIDTH:0]   w_po [1:DEPTH];
  logic [WIDTH-1:0] w_diff;
  logic             w_stall;
  logic             w_unused;

  logic [WIDTH:0]   r_g  [1:DEPTH-1];
  logic [WIDTH:0]   r_p  [1:DEPTH-1];
  logic [WIDTH-1:0] r_p0 [1:DEPTH-1];
  logic [DEPTH:1]   r_vld_pipe;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  // Index 0 carries the inverted borrow as carry-in; bits 1..WIDTH see ~b.
  always_comb begin
    w_g0    = '0;
    w_p0    = '0;
    w_g0[0] = ~bus.bin;
    for (int i = 1; i <= WIDTH; i++) begin
      w_g0[i] = bus.a[i-1] & ~bus.b[i-1];
      w_p0[i] = bus.a[i-1] ^ ~bus.b[i-1];
    end
  end

  assign w_gi[1] = w_g0;
  assign w_pi[1] = w_p0;

  for (genvar l = 2; l <= DEPTH; l++) begin : g_lin
    assign w_gi[l] = r_g[l-1];
    assign w_pi[l] = r_p[l-1];
  end

  for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
    for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
      if (((j >> (l - 1)) & 1) == 1) begin : g_cell
        localparam int SRC = j - (j % (1 << (l - 1))) - 1;
        prefix_tree_subtractor_cell u_cell (
          .i_g  (w_gi[l][j]),
          .i_p  (w_pi[l][j]),
          .i_gs (w_gi[l][SRC]),
          .i_ps (w_pi[l][SRC]),
          .o_g  (w_go[l][j]),
          .o_p  (w_po[l][j])
        );
      end else begin : g_pass
        assign w_go[l][j] = w_gi[l][j];
        assign w_po[l][j] = w_pi[l][j];
      end
    end
  end

  // Final group-generate is the carry into each bit; the last level's propagate is dead.
  assign w_diff   = r_p0[DEPTH-1] ^ w_go[DEPTH][WIDTH-1:0];
  assign w_unused = ^w_po[DEPTH];

  assign w_stall       = r_vld_pipe[DEPTH] & ~bus.out_ready;
  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_vld_pipe[DEPTH];
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int l = 1; l < DEPTH; l++) begin
        r_g[l]  <= '0;
        r_p[l]  <= '0;
        r_p0[l] <= '0;
      end
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
    end else if (!w_stall) begin
      r_vld_pipe <= {r_vld_pipe[DEPTH-1:1], bus.in_valid};
      for (int l = 1; l < DEPTH; l++) begin
        r_g[l] <= w_go[l];
        r_p[l] <= w_po[l];
      end
      r_p0[1] <= w_p0[WIDTH:1];
      for (int l = 2; l < DEPTH; l++)
        r_p0[l] <= r_p0[l-1];
      r_diff <= w_diff;
      r_bout <= ~w_go[DEPTH][WIDTH];
      r_zero <= ~|w_diff;
    end
  end

endmodule

// File: tb/tb_prefix_tree_subtractor.sv
// Randomized bench for prefix_tree_subtractor: scoreboard against plain
// unsigned arithmetic, directed corner beats, stall, mid-flight reset, width sweep.
module tb_prefix_tree_subtractor;
  localparam int W  = 8;
  localparam int D  = $clog2(W + 2);
  localparam int NV = 10000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  logic sweep_go = 1'b0;
  logic sweep_done [4];
  logic [64:0] exp_q [$];

  prefix_tree_subtractor_if #(.WIDTH(W)) bus ();
  prefix_tree_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // {borrow, diff}: borrow is the sign of the exact difference.
  function automatic logic [64:0] ref_sub(input int w, input logic [63:0] x,
                                          input logic [63:0] y, input logic c);
    logic [64:0] full;
    logic [63:0] mask;
    full = {1'b0, x} - {1'b0, y} - {64'd0, c};
    mask = (64'd1 << w) - 64'd1;
    return {full[64], full[63:0] & mask};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a_, input logic [7:0] b_, input logic c_);
    int t;
    t = 0;
    bus.a = a_; bus.b = b_; bus.bin = c_; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
    chk("send_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic beat_exp(input string tag, input logic [7:0] a_, input logic [7:0] b_,
                          input logic c_, input logic [7:0] ed, input logic eb, input logic ez);
    int lat;
    bus.a = a_; bus.b = b_; bus.bin = c_; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"},  lat, D);
    chk({tag, "_diff"}, bus.diff, ed);
    chk({tag, "_bout"}, bus.bout, eb);
    chk({tag, "_zero"}, bus.zero, ez);
    @(posedge clk); #1;
  endtask

  // Scoreboard: sampled on the falling edge, ahead of the edge that transfers.
  initial begin
    logic        stall_prev;
    logic [9:0]  held;
    logic [64:0] e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", {bus.zero, bus.bout, bus.diff}, held);
        end
        if (bus.out_valid && bus.out_ready) begin
          chk("result_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("diff", bus.diff, e[W-1:0]);
            chk("bout", bus.bout, e[64]);
            chk("zero", bus.zero, e[W-1:0] == '0);
          end
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(ref_sub(W, 64'(bus.a), 64'(bus.b), bus.bin));
        stall_prev = bus.out_valid && !bus.out_ready;
        held = {bus.zero, bus.bout, bus.diff};
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int SW = (gi == 0) ? 1 : (gi == 1) ? 7 : (gi == 2) ? 16 : 31;
    localparam int SD = $clog2(SW + 2);
    prefix_tree_subtractor_if #(.WIDTH(SW)) sbus ();
    prefix_tree_subtractor #(.WIDTH(SW)) sdut (.clk(clk), .rst(rst), .bus(sbus));

    initial begin
      logic [64:0] q [$];
      logic [64:0] e;
      logic [63:0] ra, rb, m;
      logic        rc;
      int          lat;
      string       tg;
      sweep_done[gi] = 1'b0;
      sbus.in_valid = 1'b0; sbus.out_ready = 1'b1;
      sbus.a = '0; sbus.b = '0; sbus.bin = 1'b0;
      m  = (64'd1 << SW) - 64'd1;
      tg = $sformatf("w%0d", SW);
      wait (sweep_go);
      @(posedge clk); #1;
      ra = {$urandom, $urandom} & m; rb = {$urandom, $urandom} & m; rc = 1'($urandom);
      sbus.a = ra[SW-1:0]; sbus.b = rb[SW-1:0]; sbus.bin = rc; sbus.in_valid = 1'b1;
      @(posedge clk); #1;
      sbus.in_valid = 1'b0;
      lat = 1;
      while (!sbus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      e = ref_sub(SW, ra, rb, rc);
      chk({tg, "_lat"}, lat, SD);
      chk({tg, "_lat_diff"}, 64'(sbus.diff), 64'(e[SW-1:0]));
      @(posedge clk); #1;
      for (int i = 0; i < NV + SD + 2; i++) begin
        if (i < NV) begin
          if (i < 8) begin
            ra = 64'(i & 1); rb = 64'((i >> 1) & 1); rc = 1'((i >> 2) & 1);
          end else begin
            ra = {$urandom, $urandom} & m; rb = {$urandom, $urandom} & m; rc = 1'($urandom);
          end
          sbus.a = ra[SW-1:0]; sbus.b = rb[SW-1:0]; sbus.bin = rc; sbus.in_valid = 1'b1;
        end else sbus.in_valid = 1'b0;
        @(negedge clk);
        if (sbus.in_valid) q.push_back(ref_sub(SW, ra, rb, rc));
        if (sbus.out_valid) begin
          chk({tg, "_expected"}, q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk({tg, "_diff"}, 64'(sbus.diff), 64'(e[SW-1:0]));
            chk({tg, "_bout"}, sbus.bout, e[64]);
          end
        end
        @(posedge clk); #1;
      end
      chk({tg, "_drain"}, q.size(), 0);
      sweep_done[gi] = 1'b1;
    end
  end

  initial begin
    logic        rdone;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [64:0] e;
    int          t, nd;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.bout, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_in_ready_after", bus.in_ready, 1);
    @(posedge clk); #1;

    beat_exp("basic",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    beat_exp("wrap",     8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    beat_exp("wrap_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    beat_exp("zero",     8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    beat_exp("chain",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) send(8'($urandom), 8'($urandom), 1'($urandom));

    fork
      for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
      begin
        bus.out_ready = 1'b0;
        repeat (5) begin @(negedge clk); chk("stall_in_ready", bus.in_ready, 0); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join

    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          send(8'($urandom), 8'($urandom), 1'($urandom));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (D + 3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);

    for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
    chk("pre_rst_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_diff", bus.diff, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    e = ref_sub(W, 64'(ra), 64'(rb), rc);
    beat_exp("post_rst", ra, rb, rc, e[7:0], e[64], e[7:0] == 8'h00);
    repeat (D + 2) begin @(negedge clk); chk("no_stale", bus.out_valid, 0); end
    @(posedge clk); #1;

    sweep_go = 1'b1;
    t = 0;
    nd = 0;
    while (nd != 4 && t < 30000) begin
      @(posedge clk);
      t++;
      nd = 0;
      foreach (sweep_done[k]) if (sweep_done[k]) nd++;
    end
    chk("sweep_finished", nd, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
